cva6_cap_mem_split: RTL and testbench

- Sits between the load/store unit and the XLEN-wide data-cache port, downstream of the CHERI LSU path.
- Converts each CLEN-wide capability access (size code 4, 16 B) into two sequential XLEN-wide beats, low half first, carrying the tag side-band.
- Reassembles capability loads from the two beats.
- Non-capability accesses pass through as one beat with generated byte enables.
- Applies when CheriPresent && IS_XLEN64: DCACHE_DATA_SIZE_WIDTH = 3, CLEN = 2*XLEN.

---
 rtl/cva6_cheri_pkg.sv | 37 +++
 rtl/cva6_cap_mem_split_if.sv | 49 ++++
 rtl/cva6_cap_be_gen.sv | 21 ++
 rtl/cva6_cap_mem_split.sv | 173 +++++++++++++++++
 tb/tb_cva6_cap_mem_split.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/cva6_cheri_pkg.sv
// Shared CHERI memory-path definitions: size encodings, the split-FSM state type
// and the byte-enable helper used by the LSU and the capability splitter.
package cva6_cheri_pkg;

    localparam int unsigned SIZE_WIDTH = 3;
    localparam int unsigned CAP_BYTES  = 16;

    localparam logic [SIZE_WIDTH-1:0] SIZE_B   = 3'd0;
    localparam logic [SIZE_WIDTH-1:0] SIZE_H   = 3'd1;
    localparam logic [SIZE_WIDTH-1:0] SIZE_W   = 3'd2;
    localparam logic [SIZE_WIDTH-1:0] SIZE_D   = 3'd3;
    localparam logic [SIZE_WIDTH-1:0] SIZE_CAP = 3'd4;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SEND0 = 3'd1,
        WAIT0 = 3'd2,
        SEND1 = 3'd3,
        WAIT1 = 3'd4,
        RESP  = 3'd5
    } state_e;

    // A capability beat always covers the whole 64-bit word.
    function automatic logic [7:0] be_gen(input logic [SIZE_WIDTH-1:0] size,
                                          input logic [2:0]            addr_lo);
        logic [7:0] be;
        case (size)
            SIZE_B:           be = 8'h01 << addr_lo;
            SIZE_H:           be = 8'h03 << addr_lo;
            SIZE_W:           be = 8'h0F << addr_lo;
            SIZE_D, SIZE_CAP: be = 8'hFF;
            default:          be = 8'h00;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/cva6_cap_mem_split_if.sv
// Bundle of the upstream LSU request/response and downstream XLEN cache-port signals.
interface cva6_cap_mem_split_if #(
    parameter int unsigned XLEN      = 64,
    parameter int unsigned PLEN      = 56,
    parameter int unsigned TagWidth  = 1,
    parameter int unsigned IdWidth   = 3,
    parameter int unsigned SizeWidth = 3
);
    logic                  req_valid_i;
    logic                  req_ready_o;
    logic                  req_we_i;
    logic [PLEN-1:0]       req_addr_i;
    logic [SizeWidth-1:0]  req_size_i;
    logic [2*XLEN-1:0]     req_wdata_i;
    logic [TagWidth-1:0]   req_wtag_i;
    logic [IdWidth-1:0]    req_id_i;
    logic                  rsp_valid_o;
    logic [2*XLEN-1:0]     rsp_rdata_o;
    logic [TagWidth-1:0]   rsp_rtag_o;
    logic                  rsp_err_o;
    logic [IdWidth-1:0]    rsp_id_o;
    logic                  mem_req_valid_o;
    logic                  mem_req_ready_i;
    logic                  mem_we_o;
    logic [PLEN-1:0]       mem_addr_o;
    logic [XLEN-1:0]       mem_wdata_o;
    logic [XLEN/8-1:0]     mem_be_o;
    logic [TagWidth-1:0]   mem_wtag_o;
    logic                  mem_rsp_valid_i;
    logic [XLEN-1:0]       mem_rdata_i;
    logic [TagWidth-1:0]   mem_rtag_i;
    logic                  mem_err_i;

    // The splitter itself
    modport slave (
        input  req_valid_i, req_we_i, req_addr_i, req_size_i, req_wdata_i, req_wtag_i, req_id_i,
        input  mem_req_ready_i, mem_rsp_valid_i, mem_rdata_i, mem_rtag_i, mem_err_i,
        output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_rtag_o, rsp_err_o, rsp_id_o,
        output mem_req_valid_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o, mem_wtag_o
    );

    // The surrounding LSU and data cache
    modport master (
        output req_valid_i, req_we_i, req_addr_i, req_size_i, req_wdata_i, req_wtag_i, req_id_i,
        output mem_req_ready_i, mem_rsp_valid_i, mem_rdata_i, mem_rtag_i, mem_err_i,
        input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_rtag_o, rsp_err_o, rsp_id_o,
        input  mem_req_valid_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o, mem_wtag_o
    );
endinterface

// File: rtl/cva6_cap_be_gen.sv
// Byte-enable and alignment decode for one access; illegal sizes report as misaligned.
module cva6_cap_be_gen
    import cva6_cheri_pkg::*;
(
    input  logic [SIZE_WIDTH-1:0] size_i,
    input  logic [3:0]            addr_i,
    output logic [7:0]            be_o,
    output logic                  misaligned_o
);
    always_comb begin
        be_o = be_gen(size_i, addr_i[2:0]);
        case (size_i)
            SIZE_B:   misaligned_o = 1'b0;
            SIZE_H:   misaligned_o = addr_i[0];
            SIZE_W:   misaligned_o = |addr_i[1:0];
            SIZE_D:   misaligned_o = |addr_i[2:0];
            SIZE_CAP: misaligned_o = |addr_i;
            default:  misaligned_o = 1'b1;
        endcase
    end
endmodule

// File: rtl/cva6_cap_mem_split.sv
// Splits 16-byte capability accesses into two XLEN beats (low half first) and
// reassembles loads; narrower accesses go through as a single beat.
module cva6_cap_mem_split
    import cva6_cheri_pkg::*;
#(
    parameter int unsigned XLEN      = 64,
    parameter int unsigned PLEN      = 56,
    parameter int unsigned TagWidth  = 1,
    parameter int unsigned IdWidth   = 3,
    parameter int unsigned SizeWidth = 3
) (
    input logic                 clk_i,
    input logic                 rst_ni,
    cva6_cap_mem_split_if.slave bus
);
    state_e                state_q, state_d;
    logic                  we_q, we_d;
    logic                  is_cap_q, is_cap_d;
    logic [PLEN-1:0]       addr_q, addr_d;
    logic [SizeWidth-1:0]  size_q, size_d;
    logic [2*XLEN-1:0]     wdata_q, wdata_d;
    logic [TagWidth-1:0]   wtag_q, wtag_d;
    logic [IdWidth-1:0]    id_q, id_d;
    logic [XLEN/8-1:0]     be_q, be_d;
    logic [2*XLEN-1:0]     rdata_q, rdata_d;
    logic [TagWidth-1:0]   tag_acc_q, tag_acc_d;
    logic                  err_q, err_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [2*XLEN-1:0]     rsp_rdata_q, rsp_rdata_d;
    logic [TagWidth-1:0]   rsp_rtag_q, rsp_rtag_d;
    logic                  rsp_err_q, rsp_err_d;
    logic [IdWidth-1:0]    rsp_id_q, rsp_id_d;

    logic [7:0] req_be;
    logic       req_misaligned;

    cva6_cap_be_gen u_be_gen (
        .size_i       (bus.req_size_i),
        .addr_i       (bus.req_addr_i[3:0]),
        .be_o         (req_be),
        .misaligned_o (req_misaligned)
    );

    always_comb begin
        state_d     = state_q;
        we_d        = we_q;
        is_cap_d    = is_cap_q;
        addr_d      = addr_q;
        size_d      = size_q;
        wdata_d     = wdata_q;
        wtag_d      = wtag_q;
        id_d        = id_q;
        be_d        = be_q;
        rdata_d     = rdata_q;
        tag_acc_d   = tag_acc_q;
        err_d       = err_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = '0;
        rsp_rtag_d  = '0;
        rsp_err_d   = 1'b0;
        rsp_id_d    = '0;

        case (state_q)
            IDLE: begin
                if (bus.req_valid_i) begin
                    we_d      = bus.req_we_i;
                    is_cap_d  = (bus.req_size_i == SIZE_CAP);
                    addr_d    = bus.req_addr_i;
                    size_d    = bus.req_size_i;
                    wdata_d   = bus.req_wdata_i;
                    wtag_d    = bus.req_wtag_i;
                    id_d      = bus.req_id_i;
                    be_d      = req_be;
                    rdata_d   = '0;
                    tag_acc_d = '0;
                    err_d     = req_misaligned;
                    state_d   = req_misaligned ? RESP : SEND0;
                end
            end
            SEND0: if (bus.mem_req_ready_i) state_d = WAIT0;
            WAIT0: begin
                if (bus.mem_rsp_valid_i) begin
                    rdata_d[XLEN-1:0] = bus.mem_rdata_i;
                    tag_acc_d         = bus.mem_rtag_i;
                    err_d             = bus.mem_err_i;
                    // A faulting first half aborts the capability without a second beat.
                    state_d = (!is_cap_q || bus.mem_err_i) ? RESP : SEND1;
                end
            end
            SEND1: if (bus.mem_req_ready_i) state_d = WAIT1;
            WAIT1: begin
                if (bus.mem_rsp_valid_i) begin
                    rdata_d[2*XLEN-1:XLEN] = bus.mem_rdata_i;
                    tag_acc_d              = tag_acc_q & bus.mem_rtag_i;
                    err_d                  = err_q | bus.mem_err_i;
                    state_d                = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Response fields are registered on entry to RESP so they line up with the pulse.
        if (state_d == RESP) begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = err_d;
            rsp_id_d    = id_d;
            rsp_rdata_d = (err_d || we_d) ? '0 : rdata_d;
            rsp_rtag_d  = (is_cap_d && !we_d && !err_d) ? tag_acc_d : '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            we_q        <= 1'b0;
            is_cap_q    <= 1'b0;
            addr_q      <= '0;
            size_q      <= '0;
            wdata_q     <= '0;
            wtag_q      <= '0;
            id_q        <= '0;
            be_q        <= '0;
            rdata_q     <= '0;
            tag_acc_q   <= '0;
            err_q       <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_rtag_q  <= '0;
            rsp_err_q   <= 1'b0;
            rsp_id_q    <= '0;
        end else begin
            state_q     <= state_d;
            we_q        <= we_d;
            is_cap_q    <= is_cap_d;
            addr_q      <= addr_d;
            size_q      <= size_d;
            wdata_q     <= wdata_d;
            wtag_q      <= wtag_d;
            id_q        <= id_d;
            be_q        <= be_d;
            rdata_q     <= rdata_d;
            tag_acc_q   <= tag_acc_d;
            err_q       <= err_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_rtag_q  <= rsp_rtag_d;
            rsp_err_q   <= rsp_err_d;
            rsp_id_q    <= rsp_id_d;
        end
    end

    logic in_send1;
    assign in_send1 = (state_q == SEND1);

    assign bus.req_ready_o     = rst_ni && (state_q == IDLE);
    assign bus.mem_req_valid_o = (state_q == SEND0) || in_send1;
    assign bus.mem_we_o        = we_q;
    assign bus.mem_addr_o      = is_cap_q ? {addr_q[PLEN-1:4], in_send1, 3'b000} : addr_q;
    assign bus.mem_wdata_o     = in_send1 ? wdata_q[2*XLEN-1:XLEN] : wdata_q[XLEN-1:0];
    assign bus.mem_be_o        = be_q;
    // Data stores always write a cleared tag.
    assign bus.mem_wtag_o      = is_cap_q ? wtag_q : '0;

    assign bus.rsp_valid_o = rsp_valid_q;
    assign bus.rsp_rdata_o = rsp_rdata_q;
    assign bus.rsp_rtag_o  = rsp_rtag_q;
    assign bus.rsp_err_o   = rsp_err_q;
    assign bus.rsp_id_o    = rsp_id_q;

    logic unused_size;
    assign unused_size = ^size_q;
endmodule

// File: tb/tb_cva6_cap_mem_split.sv
// Directed bench for the capability splitter: cap/data stores and loads, alignment
// errors, beat-0 error abort, backpressure stability and reset mid-transaction.
module tb_cva6_cap_mem_split;
    import cva6_cheri_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    cva6_cap_mem_split_if bus ();

    cva6_cap_mem_split dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    int cyc      = 0;
    int acc_cyc  = 0;
    int mem_cnt  = 0;
    int rsp_cnt  = 0;
    int nchk     = 0;
    int nfail    = 0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus.mem_req_valid_o) mem_cnt <= mem_cnt + 1;
        if (bus.rsp_valid_o)     rsp_cnt <= rsp_cnt + 1;
    end

    task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_req(input logic we, input logic [55:0] addr, input logic [2:0] size,
                            input logic [127:0] wdata, input logic wtag, input logic [2:0] id);
        bus.req_we_i    = we;
        bus.req_addr_i  = addr;
        bus.req_size_i  = size;
        bus.req_wdata_i = wdata;
        bus.req_wtag_i  = wtag;
        bus.req_id_i    = id;
        bus.req_valid_i = 1'b1;
        acc_cyc = cyc;
        check("req_ready", bus.req_ready_o, 1);
        @(posedge clk);
        @(negedge clk);
        bus.req_valid_i = 1'b0;
    endtask

    task automatic beat(input string tag, input logic we, input logic [55:0] addr,
                        input logic [63:0] wdata, input logic [7:0] be, input logic wtag,
                        input int delay, input bit give_rsp, input logic [63:0] rdata,
                        input logic rtag, input logic err);
        int n = 0;
        while (!bus.mem_req_valid_o && n < 10) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_valid"}, bus.mem_req_valid_o, 1);
        check({tag, "_we"},    bus.mem_we_o, we);
        check({tag, "_addr"},  bus.mem_addr_o, addr);
        check({tag, "_wdata"}, bus.mem_wdata_o, wdata);
        check({tag, "_be"},    bus.mem_be_o, be);
        check({tag, "_wtag"},  bus.mem_wtag_o, wtag);
        for (int i = 1; i <= delay; i++) begin
            @(negedge clk);
            check({tag, "_stable"},
                  {bus.mem_req_valid_o, bus.mem_we_o, bus.mem_addr_o, bus.mem_wdata_o,
                   bus.mem_be_o, bus.mem_wtag_o},
                  {1'b1, we, addr, wdata, be, wtag});
        end
        bus.mem_req_ready_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.mem_req_ready_i = 1'b0;
        if (give_rsp) begin
            bus.mem_rsp_valid_i = 1'b1;
            bus.mem_rdata_i     = rdata;
            bus.mem_rtag_i      = rtag;
            bus.mem_err_i       = err;
            @(posedge clk);
            @(negedge clk);
            bus.mem_rsp_valid_i = 1'b0;
            bus.mem_err_i       = 1'b0;
        end
    endtask

    task automatic get_rsp(input string tag, input logic [127:0] rdata, input logic rtag,
                           input logic err, input logic [2:0] id, input int lat);
        int n = 0;
        while (!bus.rsp_valid_o && n < 12) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_rsp_valid"}, bus.rsp_valid_o, 1);
        check({tag, "_rdata"},     bus.rsp_rdata_o, rdata);
        check({tag, "_rtag"},      bus.rsp_rtag_o, rtag);
        check({tag, "_err"},       bus.rsp_err_o, err);
        check({tag, "_id"},        bus.rsp_id_o, id);
        if (lat >= 0) check({tag, "_latency"}, cyc - acc_cyc, lat);
        $display("txn %s: id=%0d err=%0b rtag=%0b rdata=%032h",
                 tag, bus.rsp_id_o, bus.rsp_err_o, bus.rsp_rtag_o, bus.rsp_rdata_o);
        @(negedge clk);
        check({tag, "_pulse"}, bus.rsp_valid_o, 0);
    endtask

    initial begin
        int m0;
        int r0;
        bus.req_valid_i     = 1'b0;
        bus.req_we_i        = 1'b0;
        bus.req_addr_i      = '0;
        bus.req_size_i      = '0;
        bus.req_wdata_i     = '0;
        bus.req_wtag_i      = '0;
        bus.req_id_i        = '0;
        bus.mem_req_ready_i = 1'b0;
        bus.mem_rsp_valid_i = 1'b0;
        bus.mem_rdata_i     = '0;
        bus.mem_rtag_i      = '0;
        bus.mem_err_i       = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_req_ready", bus.req_ready_o, 0);
        check("rst_rsp_valid", bus.rsp_valid_o, 0);
        check("rst_mem_valid", bus.mem_req_valid_o, 0);
        rst_n = 1'b1;
        #1;
        check("post_rst_ready", bus.req_ready_o, 1);
        @(negedge clk);

        // Capability store, zero-wait memory
        send_req(1'b1, 56'h0000_8000_0010, SIZE_CAP,
                 {64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555}, 1'b1, 3'd3);
        beat("cst_b0", 1'b1, 56'h0000_8000_0010, 64'h5555_5555_5555_5555, 8'hFF, 1'b1,
             0, 1'b1, 64'h0, 1'b0, 1'b0);
        beat("cst_b1", 1'b1, 56'h0000_8000_0018, 64'hAAAA_AAAA_AAAA_AAAA, 8'hFF, 1'b1,
             0, 1'b1, 64'h0, 1'b0, 1'b0);
        get_rsp("cst", 128'h0, 1'b0, 1'b0, 3'd3, 5);

        // Capability load, tags 1 then 0, beat 0 back-pressured for 3 cycles
        send_req(1'b0, 56'h0000_8000_0020, SIZE_CAP, 128'h0, 1'b0, 3'd5);
        beat("cld0_b0", 1'b0, 56'h0000_8000_0020, 64'h0, 8'hFF, 1'b0,
             3, 1'b1, 64'h1111_1111_1111_1111, 1'b1, 1'b0);
        beat("cld0_b1", 1'b0, 56'h0000_8000_0028, 64'h0, 8'hFF, 1'b0,
             0, 1'b1, 64'h2222_2222_2222_2222, 1'b0, 1'b0);
        get_rsp("cld0", {64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111}, 1'b0, 1'b0, 3'd5, -1);

        // Capability load, tags 1 and 1
        send_req(1'b0, 56'h0000_8000_0030, SIZE_CAP, 128'h0, 1'b0, 3'd1);
        beat("cld1_b0", 1'b0, 56'h0000_8000_0030, 64'h0, 8'hFF, 1'b0,
             0, 1'b1, 64'h0123_4567_89AB_CDEF, 1'b1, 1'b0);
        beat("cld1_b1", 1'b0, 56'h0000_8000_0038, 64'h0, 8'hFF, 1'b0,
             0, 1'b1, 64'hFEDC_BA98_7654_3210, 1'b1, 1'b0);
        get_rsp("cld1", {64'hFEDC_BA98_7654_3210, 64'h0123_4567_89AB_CDEF}, 1'b1, 1'b0, 3'd1, 5);

        // Word store at offset 4: upper four lanes, tag forced clear
        send_req(1'b1, 56'h0000_8000_0004, SIZE_W, {64'h0, 64'hCAFE_BABE_0000_0000}, 1'b1, 3'd4);
        beat("wst", 1'b1, 56'h0000_8000_0004, 64'hCAFE_BABE_0000_0000, 8'hF0, 1'b0,
             0, 1'b1, 64'h0, 1'b0, 1'b0);
        get_rsp("wst", 128'h0, 1'b0, 1'b0, 3'd4, 3);

        // Misaligned capability: error, no beat
        m0 = mem_cnt;
        send_req(1'b0, 56'h0000_8000_0008, SIZE_CAP, 128'h0, 1'b0, 3'd2);
        get_rsp("cmis", 128'h0, 1'b0, 1'b1, 3'd2, -1);
        check("cmis_no_beat", mem_cnt - m0, 0);

        // Illegal size 5: error, no beat
        m0 = mem_cnt;
        send_req(1'b0, 56'h0000_8000_0000, 3'd5, 128'h0, 1'b0, 3'd7);
        get_rsp("sz5", 128'h0, 1'b0, 1'b1, 3'd7, -1);
        check("sz5_no_beat", mem_cnt - m0, 0);

        // Capability load erroring on beat 0: no second beat, data and tag cleared
        send_req(1'b0, 56'h0000_8000_0050, SIZE_CAP, 128'h0, 1'b0, 3'd6);
        beat("cerr_b0", 1'b0, 56'h0000_8000_0050, 64'h0, 8'hFF, 1'b0,
             3, 1'b1, 64'h3333_3333_3333_3333, 1'b1, 1'b1);
        m0 = mem_cnt;
        get_rsp("cerr", 128'h0, 1'b0, 1'b1, 3'd6, -1);
        repeat (2) @(negedge clk);
        check("cerr_no_beat1", mem_cnt - m0, 0);

        // Reset while waiting on beat 1: no response pulse afterwards
        send_req(1'b0, 56'h0000_8000_0060, SIZE_CAP, 128'h0, 1'b0, 3'd2);
        beat("crst_b0", 1'b0, 56'h0000_8000_0060, 64'h0, 8'hFF, 1'b0,
             0, 1'b1, 64'h4444_4444_4444_4444, 1'b1, 1'b0);
        beat("crst_b1", 1'b0, 56'h0000_8000_0068, 64'h0, 8'hFF, 1'b0,
             0, 1'b0, 64'h0, 1'b0, 1'b0);
        r0 = rsp_cnt;
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("crst_ready_in_rst", bus.req_ready_o, 0);
        rst_n = 1'b1;
        #1;
        check("crst_ready_after", bus.req_ready_o, 1);
        check("crst_mem_idle", bus.mem_req_valid_o, 0);
        repeat (3) @(negedge clk);
        check("crst_no_rsp", rsp_cnt - r0, 0);

        // Byte load after reset completes with its own id; tag forced 0 for data
        send_req(1'b0, 56'h0000_8000_0003, SIZE_B, 128'h0, 1'b0, 3'd6);
        beat("bld", 1'b0, 56'h0000_8000_0003, 64'h0, 8'h08, 1'b0,
             0, 1'b1, 64'h0000_0000_AB00_0000, 1'b1, 1'b0);
        get_rsp("bld", {64'h0, 64'h0000_0000_AB00_0000}, 1'b0, 1'b0, 3'd6, 3);

        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end
endmodule
